// File: rtl/az_sequencer_pkg.sv
// Shared definitions for the auto-zero sequencer: state encoding, mux codes
// and bit positions of the fields inside the 22-bit conditioning vector.
package az_sequencer_pkg;

    localparam int NUM_BITS = 22;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_SIG_SETTLE   = 3'd1,
        ST_SIG_APERTURE = 3'd2,
        ST_AZ_SETTLE    = 3'd3,
        ST_AZ_APERTURE  = 3'd4
    } state_e;

    // Mux codes are {EN,A2,A1,A0}; S(n) selects input n with EN high.
    localparam logic [3:0] SOFF = 4'b0000;
    localparam logic [3:0] S1   = 4'b1000;

    function automatic logic [3:0] s_code(input int n);
        logic [3:0] c;
        c = 4'b1000 | 4'(n - 1);
        return c;
    endfunction

    localparam int AZMUX_LSB    = 0;
    localparam int HIMUX_LSB    = 4;
    localparam int HIMUX2_LSB   = 8;
    localparam int PC_BIT       = 12;
    localparam int LED_BIT      = 13;
    localparam int MON_LSB      = 14;
    localparam int MON_APERTURE = 0;
    localparam int MON_SIG      = 1;
    localparam int MON_PAIR     = 2;

endpackage

// File: rtl/az_sequencer_if.sv
// Control/status bundle between the register set and the auto-zero sequencer.
interface az_sequencer_if #(
    parameter int CNT_W    = 24,
    parameter int NUM_BITS = 22
);
    logic                run;
    logic [3:0]          p_azmux_sig;
    logic [3:0]          p_azmux_lo;
    logic [3:0]          p_himux;
    logic [3:0]          p_himux2;
    logic [CNT_W-1:0]    p_settle;
    logic [CNT_W-1:0]    p_aperture;
    logic                irq_ack;
    logic [NUM_BITS-1:0] out;
    logic                irq;
    logic                overrun;
    logic [CNT_W-1:0]    pair_count;

    modport master (
        output run, p_azmux_sig, p_azmux_lo, p_himux, p_himux2,
        output p_settle, p_aperture, irq_ack,
        input  out, irq, overrun, pair_count
    );

    modport slave (
        input  run, p_azmux_sig, p_azmux_lo, p_himux, p_himux2,
        input  p_settle, p_aperture, irq_ack,
        output out, irq, overrun, pair_count
    );
endinterface

// File: rtl/az_sequencer_phase_timer.sv
// Loadable down-counter timing one sequencer phase; done marks the phase's
// last clock. A zero load behaves as a load of one.
module az_sequencer_phase_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    output logic             done_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = (value_i == '0) ? CNT_W'(1) : value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/az_sequencer.sv
// Auto-zero sequencer: cycles the conditioning vector through signal/zero
// phase pairs. Define AZ_SEQ_BBM_EN to add a break-before-make gap on azmux.
module az_sequencer
    import az_sequencer_pkg::*;
#(
    parameter int NUM_BITS = 22,
    parameter int CNT_W    = 24,
    parameter int BBM_CLKS = 2
) (
    input  logic          clk,
    input  logic          reset,
    az_sequencer_if.slave bus
);
    state_e              state_q, state_d;
    logic [3:0]          sig_q, sig_d, lo_q, lo_d, hi_q, hi_d, hi2_q, hi2_d;
    logic [CNT_W-1:0]    settle_q, settle_d, aper_q, aper_d;
    logic [CNT_W-1:0]    pairs_q, pairs_d;
    logic                irq_q, irq_d, ovr_q, ovr_d, led_q, led_d;
    logic [NUM_BITS-1:0] out_q, out_d;
    logic                tmr_load, tmr_done, pair_end;
    logic [CNT_W-1:0]    tmr_value;
    logic [3:0]          code_new, az_out;

`ifdef AZ_SEQ_BBM_EN
    localparam int BBM_W = (BBM_CLKS < 1) ? 1 : $clog2(BBM_CLKS + 1);
    logic [BBM_W-1:0] bbm_q, bbm_d;
    logic [3:0]       code_cur;
`else
    logic unused_bbm;
    assign unused_bbm = ^BBM_CLKS;
`endif

    function automatic logic [3:0] az_code(input state_e s, input logic [3:0] sig,
                                           input logic [3:0] lo);
        case (s)
            ST_SIG_SETTLE, ST_SIG_APERTURE: return sig;
            ST_AZ_SETTLE,  ST_AZ_APERTURE:  return lo;
            default:                        return SOFF;
        endcase
    endfunction

    az_sequencer_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load_i  (tmr_load),
        .value_i (tmr_value),
        .done_o  (tmr_done)
    );

    assign pair_end = (state_q == ST_AZ_APERTURE) && tmr_done;

    always_comb begin
        state_d  = state_q;
        sig_d    = sig_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        hi2_d    = hi2_q;
        settle_d = settle_q;
        aper_d   = aper_q;

        case (state_q)
            ST_IDLE:         if (bus.run)  state_d = ST_SIG_SETTLE;
            ST_SIG_SETTLE:   if (tmr_done) state_d = ST_SIG_APERTURE;
            ST_SIG_APERTURE: if (tmr_done) state_d = ST_AZ_SETTLE;
            ST_AZ_SETTLE:    if (tmr_done) state_d = ST_AZ_APERTURE;
            ST_AZ_APERTURE:  if (tmr_done) state_d = bus.run ? ST_SIG_SETTLE : ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase

        // Parameters are sampled once per pair so a pair never mixes settings.
        if (state_d == ST_SIG_SETTLE && state_q != ST_SIG_SETTLE) begin
            sig_d    = bus.p_azmux_sig;
            lo_d     = bus.p_azmux_lo;
            hi_d     = bus.p_himux;
            hi2_d    = bus.p_himux2;
            settle_d = bus.p_settle;
            aper_d   = bus.p_aperture;
        end

        tmr_load  = (state_d != state_q) && (state_d != ST_IDLE);
        tmr_value = (state_d == ST_SIG_SETTLE || state_d == ST_AZ_SETTLE) ? settle_d : aper_d;

        irq_d = irq_q;
        if (pair_end)         irq_d = 1'b1;
        else if (bus.irq_ack) irq_d = 1'b0;
        ovr_d   = ovr_q | (pair_end & irq_q);
        pairs_d = pair_end ? pairs_q + CNT_W'(1) : pairs_q;
        led_d   = led_q ^ pair_end;

        code_new = az_code(state_d, sig_d, lo_d);
`ifdef AZ_SEQ_BBM_EN
        code_cur = az_code(state_q, sig_q, lo_q);
        bbm_d    = bbm_q;
        if (tmr_load && (code_new != code_cur)) begin
            bbm_d = BBM_W'(BBM_CLKS);
        end else if (bbm_q != '0) begin
            bbm_d = bbm_q - BBM_W'(1);
        end
        az_out = (bbm_d != '0) ? SOFF : code_new;
`else
        az_out = code_new;
`endif

        // Outside a run only led0 survives; the pair-done pulse is suppressed too.
        out_d          = '0;
        out_d[LED_BIT] = led_d;
        if (state_d != ST_IDLE) begin
            out_d[AZMUX_LSB +: 4]  = az_out;
            out_d[HIMUX_LSB +: 4]  = hi_d;
            out_d[HIMUX2_LSB +: 4] = hi2_d;
            out_d[PC_BIT]          = (state_d == ST_SIG_SETTLE) || (state_d == ST_SIG_APERTURE);
            out_d[MON_LSB + MON_APERTURE] =
                (state_d == ST_SIG_APERTURE) || (state_d == ST_AZ_APERTURE);
            out_d[MON_LSB + MON_SIG] =
                (state_d == ST_SIG_SETTLE) || (state_d == ST_SIG_APERTURE);
            out_d[MON_LSB + MON_PAIR] = pair_end;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sig_q    <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            hi2_q    <= '0;
            settle_q <= '0;
            aper_q   <= '0;
            pairs_q  <= '0;
            irq_q    <= 1'b0;
            ovr_q    <= 1'b0;
            led_q    <= 1'b0;
            out_q    <= '0;
`ifdef AZ_SEQ_BBM_EN
            bbm_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sig_q    <= sig_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            hi2_q    <= hi2_d;
            settle_q <= settle_d;
            aper_q   <= aper_d;
            pairs_q  <= pairs_d;
            irq_q    <= irq_d;
            ovr_q    <= ovr_d;
            led_q    <= led_d;
            out_q    <= out_d;
`ifdef AZ_SEQ_BBM_EN
            bbm_q    <= bbm_d;
`endif
        end
    end

    assign bus.out        = out_q;
    assign bus.irq        = irq_q;
    assign bus.overrun    = ovr_q;
    assign bus.pair_count = pairs_q;
endmodule
